even_parity_frame_rx: RTL and testbench
=======================================

# even_parity_frame_rx

Serial-to-parallel front end for the 3-bit even-parity checker. It deserializes a UART-style frame (start, three data bits, parity bit, stop) from a single-bit line and presents A, B, C and p as registered parallel outputs with a valid/ready handshake. The checker consumes these outputs directly. This block does no parity evaluation: frames with bad parity are delivered unchanged, and only framing faults are flagged here.

## Interface
- CLKS_PER_BIT, default 4: clock cycles per serial bit period. Legal range 4..255. Called N below.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- sdi  in  1  serial data line. Already synchronous to clk, so no internal synchronizer. Idle level is 1.
- out_ready  in  1  downstream accepts the current word this cycle.
- A  out  1  first data bit received.
- B  out  1  second data bit received.
- C  out  1  third data bit received.
- p  out  1  received parity bit.
- out_valid  out  1  A/B/C/p hold a complete frame.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: a good frame was dropped because the output was still occupied.

## Operation
- Frame on sdi, in order: start (0), A, B, C, p, stop (1). Each bit lasts N cycles.
- State machine states: IDLE, START, DATA, PARITY, STOP, BREAK. A bit-period counter is 8 bits wide; a data-bit index runs 0..2.
- IDLE:
  - sdi==0 sampled at edge t0: go to START and clear the counter.
  - Otherwise remain in IDLE.
- START:
  - Re-sample sdi at edge t0+N/2 (integer division).
  - If sdi==1, this is a false start: return to IDLE with no outputs.
  - If sdi==0, go to DATA with the counter cleared.
- DATA: sample one bit every N cycles, at edges t0+N/2+N, +2N and +3N, into A, B and C respectively. Shift these into internal registers, not into the outputs. After C, go to PARITY.
- PARITY: sample p at edge t0+N/2+4N, then go to STOP.
- STOP: sample at edge t0+N/2+5N (the stop edge).
  - sdi==1 (good frame): commit the frame to the outputs per the rules below, then go to IDLE. A new start can be detected from the very next edge.
  - sdi==0: pulse frame_err, discard the frame and go to BREAK.
- BREAK: stay until sdi==1 is sampled, then go to IDLE. A line held low never produces further frames or errors.
- Output handshake:
  - A transfer occurs on any edge where out_valid && out_ready.
  - When a transfer happens and no commit coincides, out_valid drops to 0 on that edge.
  - A/B/C/p are stable whenever out_valid==1 and change only on a commit.
- Commit on a good stop edge:
  - If out_valid==0, or (out_valid==1 and out_ready==1) on that edge: load A/B/C/p and set out_valid to 1. In the second case the old word transfers and the new word replaces it with no valid gap.
  - If out_valid==1 and out_ready==0: keep the old word, drop the new one, and pulse overrun.
- Reset (rst==1 at any edge, including mid-frame): state goes to IDLE, the counter and bit index clear, the in-flight frame is discarded, and all outputs clear.

## Timing
- Reset values: A=B=C=p=0, out_valid=0, frame_err=0, overrun=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Latency:
  - A good frame becomes visible, with out_valid=1, in the cycle after the stop edge, i.e. from cycle t0+N/2+5N+1.
  - frame_err and overrun are high for exactly the cycle after the stop edge.
- Sampling:
  - The false-start filter rejects any low pulse shorter than N/2+1 cycles.
  - Each bit is sampled once, mid-period, with no majority vote.
- Simultaneous events:
  - rst has priority over everything else.
  - Commit with out_ready==1 on the same edge: transfer and reload (valid stays 1, no overrun).
  - frame_err and overrun never assert together.
- Throughput: back-to-back frames are accepted with zero idle cycles between the stop bit and the next start bit. The bit-period counter wraps to 0 at N-1 each bit.

## Test plan
- Good frame, N=4: A=1, B=0, C=1, p=0, out_ready=0. Require out_valid rising at t0+23, A/B/C/p=1/0/1/0, held for 10 cycles. Then drive out_ready=1 for 1 cycle: require out_valid=0 on the next cycle.
- False start: sdi low for 2 cycles, then high. Require the FSM to return to IDLE, out_valid to stay 0, and no frame_err. Then send a good frame and require it to be received correctly.
- Framing error: stop bit driven to 0, line held low for 20 cycles. Require exactly one frame_err pulse at t0+23, no out_valid, and no further pulses. Then raise sdi and send a good frame: require normal reception.
- Overrun:
  - Send two back-to-back frames (1,1,0,0) then (0,1,1,0) with out_ready=0. Require overrun pulsed once and outputs still 1/1/0/0.
  - Repeat with out_ready=1 on the second stop edge. Require no overrun, outputs 0/1/1/0, and out_valid continuously 1.
- Reset mid-frame: assert rst for 1 cycle during DATA of a frame. Require all outputs 0 and no valid for that frame. A following full frame must be received correctly.
- Bad parity passthrough: A=1, B=1, C=1, p=0. Require delivery of 1/1/1/0 with out_valid=1 and no error flag.

Source files
------------

// File: rtl/even_parity_frame_rx_if.sv
// Parallel output side of the even-parity frame receiver: one received word,
// a valid/ready handshake, and single-cycle fault pulses.
interface even_parity_frame_rx_if;
  logic A;
  logic B;
  logic C;
  logic p;
  logic out_valid;
  logic out_ready;
  logic frame_err;
  logic overrun;

  modport master (
    output A, B, C, p, out_valid, frame_err, overrun,
    input  out_ready
  );

  modport slave (
    input  A, B, C, p, out_valid, frame_err, overrun,
    output out_ready
  );
endinterface

// File: rtl/even_parity_frame_rx.sv
// Deserializes start/A/B/C/p/stop frames from sdi into a registered word with a
// valid/ready handshake. Parity is passed through; only framing faults are flagged.
module even_parity_frame_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sdi,
  even_parity_frame_rx_if.master bus
);

  localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] BIT_M1  = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] idx, idx_n;
  logic [2:0] sh, sh_n;
  logic       par, par_n;
  logic       good, bad;

  logic [3:0] word_q;
  logic       valid_q;
  logic       ferr_q;
  logic       ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
      par   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sh    <= sh_n;
      par   <= par_n;
    end
  end

  // The counter counts edges since the last sample point, so a sample fires
  // when it reaches HALF_M1 (start check) or BIT_M1 (every later bit).
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 8'd1;
    idx_n   = idx;
    sh_n    = sh;
    par_n   = par;
    good    = 1'b0;
    bad     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!sdi) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = sdi ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          sh_n  = {sh[1:0], sdi};
          if (idx == 2'd2) begin
            idx_n   = '0;
            state_n = PARITY;
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
      PARITY: begin
        if (cnt == BIT_M1) begin
          cnt_n   = '0;
          par_n   = sdi;
          state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_n = '0;
          if (sdi) begin
            good    = 1'b1;
            state_n = IDLE;
          end else begin
            bad     = 1'b1;
            state_n = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (sdi) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // A commit with out_ready high transfers the old word and reloads in the
  // same edge, so out_valid never gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ferr_q <= bad;
      ovr_q  <= good && valid_q && !bus.out_ready;
      if (good && (!valid_q || bus.out_ready)) begin
        word_q  <= {sh, par};
        valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.A         = word_q[3];
  assign bus.B         = word_q[2];
  assign bus.C         = word_q[1];
  assign bus.p         = word_q[0];
  assign bus.out_valid = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_even_parity_frame_rx.sv
// Directed and randomized frames on sdi, checked every cycle against a model
// that predicts the stop-edge time arithmetically from the frame start.
module tb_even_parity_frame_rx;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  logic sdi;

  even_parity_frame_rx_if bus ();

  even_parity_frame_rx #(.CLKS_PER_BIT(N)) dut (
    .clk (clk),
    .rst (rst),
    .sdi (sdi),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         nasrt = 0;
  int         nfail = 0;
  int         cyc   = 0;
  int         rmode = 0;

  // reference state: last committed word and the one pending stop event
  logic       m_valid = 1'b0;
  logic [3:0] m_word  = '0;
  logic       m_ferr  = 1'b0;
  logic       m_ovr   = 1'b0;
  int         ev_cyc  = -1;
  logic       ev_good = 1'b0;
  logic [3:0] ev_word = '0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nasrt++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    if (rmode == 1) bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    cyc++;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_word  = '0;
      ev_cyc  = -1;
    end else if (cyc == ev_cyc && ev_good) begin
      if (!m_valid || bus.out_ready) begin
        m_word  = ev_word;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else begin
      if (cyc == ev_cyc) m_ferr = 1'b1;
      if (m_valid && bus.out_ready) m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 8'(bus.out_valid), 8'(m_valid));
    chk("word_ABCp", 8'({bus.A, bus.B, bus.C, bus.p}), 8'(m_word));
    chk("frame_err", 8'(bus.frame_err), 8'(m_ferr));
    chk("overrun", 8'(bus.overrun), 8'(m_ovr));
  endtask

  task automatic hold(input logic level, input int n);
    sdi = level;
    rst = 1'b0;
    repeat (n) tick();
  endtask

  // rsel 2: out_ready high only on the stop-sample edge of this frame
  task automatic send_frame(input logic a, input logic b, input logic c, input logic pp,
                            input logic stop, input int rst_off, input int rsel);
    logic [5:0] bits;
    bits    = {stop, pp, c, b, a, 1'b0};
    ev_cyc  = cyc + 1 + N / 2 + 5 * N;
    ev_good = stop;
    ev_word = {a, b, c, pp};
    for (int j = 0; j < 6; j++) begin
      for (int k = 0; k < N; k++) begin
        sdi = bits[j];
        rst = (j * N + k == rst_off);
        if (rsel == 2) bus.out_ready = (j == 5 && k == N / 2);
        tick();
      end
    end
    rst = 1'b0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    hold(1'b1, 1);
    bus.out_ready = 1'b0;
    hold(1'b1, 1);
  endtask

  initial begin
    logic [3:0] d;
    logic       stp;
    sdi = 1'b1;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    hold(1'b1, 3);

    // good frame held with out_ready low, then a single-cycle accept
    send_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1, 0);
    hold(1'b1, 10);
    bus.out_ready = 1'b1;
    hold(1'b1, 1);
    bus.out_ready = 1'b0;
    hold(1'b1, 2);

    // false start shorter than the filter, then a real frame
    hold(1'b0, 2);
    hold(1'b1, 6);
    send_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    drain();

    // framing error with the line held low afterwards
    send_frame(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, 0);
    hold(1'b0, 20);
    hold(1'b1, 2);
    send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, -1, 0);
    drain();

    // back-to-back frames: overrun, then same-edge transfer and reload
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    hold(1'b1, 2);
    drain();
    send_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0);
    send_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, -1, 2);
    hold(1'b1, 2);
    drain();

    // reset during the A bit period, then a full frame
    send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, N + 2, 0);
    hold(1'b1, 3);
    send_frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
    drain();

    // bad parity is delivered untouched
    send_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0);
    hold(1'b1, 3);
    drain();

    // random frames, gaps, stop faults and out_ready
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      d   = 4'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      send_frame(d[3], d[2], d[1], d[0], stp, -1, 0);
      if (!stp) begin
        hold(1'b0, $urandom_range(0, 6));
        hold(1'b1, $urandom_range(1, 3));
      end else begin
        hold(1'b1, $urandom_range(0, 3));
      end
    end
    rmode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end

endmodule
